// File: rtl/dmac_channel_engine.sv
// DMA channel: alternating read/write bursts through an internal FIFO. Optional circular mode under DMAC_CIRCULAR_EN.
// Latency: first beat request one cycle after start; one beat per cycle while m_ready is high.
// Backpressure: m_ready low holds m_req/m_addr/m_wdata; abort cancels at the next edge and flushes the FIFO.

module dmac_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  // Pointers wrap naturally; the sequencer never pushes more than DEPTH before draining.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
    end
  end

  assign dout = mem[rd_ptr];
endmodule

module dmac_channel_engine #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [CNT_W-1:0]  xfer_size,
  input  logic [CNT_W-1:0]  burst_size,
  input  logic [1:0]        beat_size,
  input  logic              src_fixed,
  input  logic              dst_fixed,
`ifdef DMAC_CIRCULAR_EN
  input  logic              circ,
`endif
  output logic              m_req,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [1:0]        m_size,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [CNT_W-1:0]  remaining
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] src_cur, dst_cur, src_step, dst_step;
  logic [CNT_W-1:0]  burst_q, burst_len, beat_cnt, remaining_q, burst_eff;
  logic [1:0]        size_q;
  logic              src_fx, dst_fx, aborted_q;
  logic              abort_ok, beat_ok, last_beat;
  logic              fifo_flush, fifo_push, fifo_pop;
  logic [DATA_W-1:0] fifo_head;
`ifdef DMAC_CIRCULAR_EN
  logic              circ_q;
  logic [ADDR_W-1:0] src_base, dst_base;
  logic [CNT_W-1:0]  xfer_q;
`endif

  function automatic logic [CNT_W-1:0] min_cnt(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Abort outranks any beat completing in the same cycle, so that beat is not consumed.
  assign abort_ok  = abort && (state != S_IDLE);
  assign beat_ok   = m_req && m_ready && !abort_ok;
  assign last_beat = (beat_cnt == burst_len - ONE_C);
  assign burst_eff = (burst_size == '0) ? ONE_C : (burst_size > DEPTH_C) ? DEPTH_C : burst_size;
  assign src_step  = src_fx ? '0 : (ADDR_W'(1) << size_q);
  assign dst_step  = dst_fx ? '0 : (ADDR_W'(1) << size_q);

  assign m_req     = (state == S_RD) || (state == S_WR);
  assign m_write   = (state == S_WR);
  assign m_addr    = (state == S_WR) ? dst_cur : (state == S_RD) ? src_cur : '0;
  assign m_size    = size_q;
  assign m_wdata   = m_write ? fifo_head : '0;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign aborted   = aborted_q;
  assign remaining = remaining_q;

  assign fifo_flush = abort_ok;
  assign fifo_push  = beat_ok && (state == S_RD);
  assign fifo_pop   = beat_ok && (state == S_WR);

  dmac_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (fifo_flush),
    .push  (fifo_push),
    .din   (m_rdata),
    .pop   (fifo_pop),
    .dout  (fifo_head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      src_cur     <= '0;
      dst_cur     <= '0;
      burst_q     <= '0;
      burst_len   <= '0;
      beat_cnt    <= '0;
      remaining_q <= '0;
      size_q      <= '0;
      src_fx      <= 1'b0;
      dst_fx      <= 1'b0;
      aborted_q   <= 1'b0;
`ifdef DMAC_CIRCULAR_EN
      circ_q      <= 1'b0;
      src_base    <= '0;
      dst_base    <= '0;
      xfer_q      <= '0;
`endif
    end else begin
      aborted_q <= 1'b0;
      if (abort_ok) begin
        state     <= S_IDLE;
        beat_cnt  <= '0;
        aborted_q <= 1'b1;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            src_cur     <= src_addr;
            dst_cur     <= dst_addr;
            burst_q     <= burst_eff;
            burst_len   <= min_cnt(burst_eff, xfer_size);
            beat_cnt    <= '0;
            remaining_q <= xfer_size;
            size_q      <= beat_size;
            src_fx      <= src_fixed;
            dst_fx      <= dst_fixed;
`ifdef DMAC_CIRCULAR_EN
            circ_q      <= circ;
            src_base    <= src_addr;
            dst_base    <= dst_addr;
            xfer_q      <= xfer_size;
`endif
            state       <= (xfer_size == '0) ? S_DONE : S_RD;
          end
          S_RD: if (beat_ok) begin
            src_cur <= src_cur + src_step;
            if (last_beat) begin
              beat_cnt <= '0;
              state    <= S_WR;
            end else begin
              beat_cnt <= beat_cnt + ONE_C;
            end
          end
          S_WR: if (beat_ok) begin
            dst_cur     <= dst_cur + dst_step;
            remaining_q <= remaining_q - ONE_C;
            if (last_beat) begin
              beat_cnt  <= '0;
              burst_len <= min_cnt(burst_q, remaining_q - ONE_C);
              state     <= (remaining_q == ONE_C) ? S_DONE : S_RD;
            end else begin
              beat_cnt <= beat_cnt + ONE_C;
            end
          end
          S_DONE: begin
`ifdef DMAC_CIRCULAR_EN
            if (circ_q) begin
              src_cur     <= src_base;
              dst_cur     <= dst_base;
              remaining_q <= xfer_q;
              burst_len   <= min_cnt(burst_q, xfer_q);
              beat_cnt    <= '0;
              state       <= (xfer_q == '0) ? S_DONE : S_RD;
            end else begin
              state <= S_IDLE;
            end
`else
            state <= S_IDLE;
`endif
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
